// File: rtl/if_fetch_unit_pkg.sv
// Fetch stage shared types and constants.
// Word type, NOP encoding, FSM states, buffer entry.
package if_fetch_unit_pkg;

  typedef logic [31:0] word_t;

  localparam word_t INS_NOP = 32'h0000_0013;
  localparam word_t PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    word_t addr;
    word_t ins;
  } fetch_entry_t;

  function automatic word_t word_align(
    input word_t a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch stage buses: imem req/gnt/rvalid and IF/ID valid/ready.
// master = fetch unit, slave = memory + decode side.
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  logic  if2mem_req_o;
  word_t if2mem_addr_o;
  logic  mem2if_gnt_i;
  logic  mem2if_rvalid_i;
  word_t mem2if_rdata_i;
  logic  if2ifid_valid_o;
  word_t if2ifid_ins_o;
  word_t if2ifid_addr_o;
  logic  ifid2if_ready_i;

  modport master (
    output if2mem_req_o,
    output if2mem_addr_o,
    input  mem2if_gnt_i,
    input  mem2if_rvalid_i,
    input  mem2if_rdata_i,
    output if2ifid_valid_o,
    output if2ifid_ins_o,
    output if2ifid_addr_o,
    input  ifid2if_ready_i
  );

  modport slave (
    input  if2mem_req_o,
    input  if2mem_addr_o,
    output mem2if_gnt_i,
    output mem2if_rvalid_i,
    output mem2if_rdata_i,
    input  if2ifid_valid_o,
    input  if2ifid_ins_o,
    input  if2ifid_addr_o,
    output ifid2if_ready_i
  );

endinterface

// File: rtl/if_fetch_fifo.sv
// Fetch buffer: small sync FIFO of {addr,ins} entries.
// Flush wins over push/pop; push+pop when full is legal.
module if_fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Payload storage needs no reset; count guards reads.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, imem handshake, fetch buffer.
// Redirects flush the buffer and drop wrong-path responses.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC   = 32'h0000_0000,
  parameter int    FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  if_fetch_unit_if.master        bus,
  input  logic                   ex2if_jump_en_i,
  input  word_t                  ex2if_jump_addr_i
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 2;

  fetch_state_e  state;
  word_t         pc;
  word_t         resp_pc;
  word_t         target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] drop_nxt;
  logic [CW-1:0] fifo_cnt;
  logic [SW-1:0] inflight;
  logic          fifo_empty;
  logic          fifo_full;
  logic          jump;
  logic          issue;
  logic          fire;
  logic          rv_live;
  logic          rv_drop;
  logic          push;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  push_data;

  assign jump     = ex2if_jump_en_i;
  assign target   = word_align(ex2if_jump_addr_i);
  assign inflight = SW'(outstanding) + SW'(drop_cnt)
                  + SW'(fifo_cnt);

  // Every issued word is guaranteed a buffer slot.
  assign issue = (state != S_IDLE) && !jump && !fifo_full
              && (inflight < SW'(FIFO_DEPTH));
  assign fire  = issue && bus.mem2if_gnt_i;

  // rvalid with nothing tracked is stale (pre-reset).
  assign rv_live = bus.mem2if_rvalid_i
                && (outstanding != '0 || drop_cnt != '0);
  assign rv_drop = rv_live && (drop_cnt != '0);
  assign push    = rv_live && (drop_cnt == '0) && !jump;
  assign pop     = !fifo_empty && bus.ifid2if_ready_i
                && !jump;

  // Buffer entry tagged with the in-order response PC.
  always_comb begin
    push_data      = '0;
    push_data.addr = resp_pc;
    push_data.ins  = bus.mem2if_rdata_i;
  end

  // Next outstanding / drop counts.
  always_comb begin
    out_nxt  = outstanding;
    drop_nxt = drop_cnt;
    unique case (1'b1)
      jump: begin
        out_nxt  = '0;
        drop_nxt = drop_cnt + outstanding - CW'(rv_live);
      end
      !jump: begin
        out_nxt  = outstanding + CW'(fire) - CW'(push);
        drop_nxt = drop_cnt - CW'(rv_drop);
      end
    endcase
  end

  // Fetch FSM and in-flight counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_nxt;
      drop_cnt    <= drop_nxt;
      unique case (state)
        S_IDLE:  state <= S_RUN;
        S_RUN:   if (jump && drop_nxt != '0) state <= S_DRAIN;
        S_DRAIN: if (!jump && drop_nxt == '0) state <= S_RUN;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Fetch PC and response-tag PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      resp_pc <= RESET_PC;
    end else if (jump) begin
      pc      <= target;
      resp_pc <= target;
    end else begin
      if (fire) pc      <= pc + PC_STEP;
      if (push) resp_pc <= resp_pc + PC_STEP;
    end
  end

  if_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (jump),
    .wdata (push_data),
    .rdata (head),
    .count (fifo_cnt),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.if2mem_req_o    = issue;
  assign bus.if2mem_addr_o   = pc;
  assign bus.if2ifid_valid_o = !fifo_empty;
  assign bus.if2ifid_ins_o   = fifo_empty ? INS_NOP : head.ins;
  assign bus.if2ifid_addr_o  = fifo_empty ? '0 : head.addr;

endmodule
